// File: rtl/ldst_unit.sv
// Load/store unit: moves one execute-stage instruction per transaction into write-back,
// issuing an aligned data-memory request for loads and stores.
module ldst_unit #(
    parameter int DataWidth    = 32,
    parameter int RegAddrWidth = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    exe_valid,
    input  logic                    exe_memtoreg,
    input  logic                    exe_memwrite,
    input  logic [2:0]              exe_funct3,
    input  logic [DataWidth-1:0]    exe_alu_result,
    input  logic [DataWidth-1:0]    exe_store_data,
    input  logic [RegAddrWidth-1:0] exe_addr_dst,
    output logic                    ldst_stall,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [DataWidth-1:0]    dmem_addr,
    output logic [DataWidth-1:0]    dmem_wdata,
    output logic [3:0]              dmem_be,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [DataWidth-1:0]    dmem_rdata,
    output logic                    ldst_valid,
    output logic                    ldst_memtoreg,
    output logic [RegAddrWidth-1:0] ldst_addr_dst,
    output logic [DataWidth-1:0]    ldst_alu_result,
    output logic [DataWidth-1:0]    ldst_load_data,
    output logic                    ldst_misaligned,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    // Handshake: a memory request transfers on a rising edge with dmem_req=1 and dmem_gnt=1;
    // addr/we/wdata/be stay stable from dmem_req rising until that edge. dmem_rvalid is
    // honoured only in RESP, dmem_gnt only in REQ.
    state_t                  state;
    logic                    is_load_q;
    logic [1:0]              size_q;
    logic                    unsigned_q;
    logic [1:0]              offset_q;
    logic [RegAddrWidth-1:0] addr_dst_q;

    logic                 is_mem, is_byte, is_half, misaligned;
    logic [1:0]           offset;
    logic [3:0]           be_n;
    logic [DataWidth-1:0] wdata_n;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [DataWidth-1:0] load_ext;

    // Unsupported size codes (011, 110, 111) fall through to word.
    assign is_mem     = exe_memtoreg | exe_memwrite;
    assign is_byte    = (exe_funct3[1:0] == 2'b00);
    assign is_half    = (exe_funct3[1:0] == 2'b01);
    assign offset     = exe_alu_result[1:0];
    assign misaligned = is_mem & ((is_half & offset[0]) |
                                  (!is_byte & !is_half & (offset != 2'b00)));
    assign ldst_stall = (state != IDLE) | (exe_valid & is_mem & !misaligned);
    assign dbg_state  = state;

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = exe_store_data;
        if (is_byte) begin
            be_n    = 4'b0001 << offset;
            wdata_n = {(DataWidth/8){exe_store_data[7:0]}};
        end else if (is_half) begin
            be_n    = 4'b0011 << offset;
            wdata_n = {(DataWidth/16){exe_store_data[15:0]}};
        end
    end

    assign ld_byte = dmem_rdata[{offset_q, 3'b000} +: 8];
    assign ld_half = dmem_rdata[{offset_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = dmem_rdata;
        case (size_q)
            2'b00: load_ext = {{(DataWidth-8){ld_byte[7] & !unsigned_q}}, ld_byte};
            2'b01: load_ext = {{(DataWidth-16){ld_half[15] & !unsigned_q}}, ld_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            is_load_q       <= 1'b0;
            size_q          <= 2'b00;
            unsigned_q      <= 1'b0;
            offset_q        <= 2'b00;
            addr_dst_q      <= '0;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            dmem_be         <= 4'b0000;
            ldst_valid      <= 1'b0;
            ldst_memtoreg   <= 1'b0;
            ldst_addr_dst   <= '0;
            ldst_alu_result <= '0;
            ldst_load_data  <= '0;
            ldst_misaligned <= 1'b0;
        end else begin
            ldst_valid      <= 1'b0;
            ldst_misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (exe_valid) begin
                        if (!is_mem) begin
                            ldst_valid      <= 1'b1;
                            ldst_memtoreg   <= 1'b0;
                            ldst_addr_dst   <= exe_addr_dst;
                            ldst_alu_result <= exe_alu_result;
                        end else if (misaligned) begin
                            ldst_misaligned <= 1'b1;
                        end else begin
                            state           <= REQ;
                            is_load_q       <= exe_memtoreg;
                            size_q          <= is_byte ? 2'b00 : (is_half ? 2'b01 : 2'b10);
                            unsigned_q      <= exe_funct3[2];
                            offset_q        <= offset;
                            addr_dst_q      <= exe_addr_dst;
                            ldst_alu_result <= exe_alu_result;
                            dmem_req        <= 1'b1;
                            dmem_we         <= !exe_memtoreg;
                            dmem_addr       <= {exe_alu_result[DataWidth-1:2], 2'b00};
                            dmem_wdata      <= wdata_n;
                            dmem_be         <= be_n;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (is_load_q) begin
                            state <= RESP;
                        end else begin
                            state         <= IDLE;
                            ldst_valid    <= 1'b1;
                            ldst_memtoreg <= 1'b0;
                            ldst_addr_dst <= '0;
                        end
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        state          <= IDLE;
                        ldst_valid     <= 1'b1;
                        ldst_memtoreg  <= 1'b1;
                        ldst_addr_dst  <= addr_dst_q;
                        ldst_load_data <= load_ext;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldst_unit.sv
// Directed bench for ldst_unit: ALU pass-through, loads, stores, misalignment, size fallback
// and reset in the middle of a load.
module tb_ldst_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exe_valid, exe_memtoreg, exe_memwrite;
    logic [2:0]  exe_funct3;
    logic [31:0] exe_alu_result, exe_store_data;
    logic [9:0]  exe_addr_dst;
    logic        ldst_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        ldst_valid, ldst_memtoreg, ldst_misaligned;
    logic [9:0]  ldst_addr_dst;
    logic [31:0] ldst_alu_result, ldst_load_data;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ldst_unit #(.DataWidth(32), .RegAddrWidth(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .exe_valid(exe_valid), .exe_memtoreg(exe_memtoreg), .exe_memwrite(exe_memwrite),
        .exe_funct3(exe_funct3), .exe_alu_result(exe_alu_result),
        .exe_store_data(exe_store_data), .exe_addr_dst(exe_addr_dst),
        .ldst_stall(ldst_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .ldst_valid(ldst_valid), .ldst_memtoreg(ldst_memtoreg),
        .ldst_addr_dst(ldst_addr_dst), .ldst_alu_result(ldst_alu_result),
        .ldst_load_data(ldst_load_data), .ldst_misaligned(ldst_misaligned),
        .dbg_state(dbg_state)
    );

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [9:0] dst);
        exe_valid      = 1'b1;
        exe_memtoreg   = ld;
        exe_memwrite   = st;
        exe_funct3     = f3;
        exe_alu_result = addr;
        exe_store_data = sdata;
        exe_addr_dst   = dst;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; exe_valid = 0; exe_memtoreg = 0; exe_memwrite = 0; exe_funct3 = 0;
        exe_alu_result = 0; exe_store_data = 0; exe_addr_dst = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({ldst_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, ldst_valid,
                      ldst_memtoreg, ldst_addr_dst, ldst_alu_result, ldst_load_data,
                      ldst_misaligned} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got nonzero output, required all 0");
        end
        n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_op();
        drive_op(0, 0, 3'b000, 32'h1234, 32'h0, 10'd5);
        #1;
        n_cmp++; if (ldst_stall !== 1'b0) begin n_err++; $display("FAIL alu_stall_accept: got %b required 0", ldst_stall); end
        @(negedge clk);
        exe_valid = 0;
        n_cmp++; if (ldst_valid !== 1'b1) begin n_err++; $display("FAIL alu_valid: got %b required 1", ldst_valid); end
        n_cmp++; if (ldst_memtoreg !== 1'b0) begin n_err++; $display("FAIL alu_memtoreg: got %b required 0", ldst_memtoreg); end
        n_cmp++; if (ldst_alu_result !== 32'h1234) begin n_err++; $display("FAIL alu_result: got %h required 00001234", ldst_alu_result); end
        n_cmp++; if (ldst_addr_dst !== 10'd5) begin n_err++; $display("FAIL alu_dst: got %0d required 5", ldst_addr_dst); end
        n_cmp++; if (ldst_stall !== 1'b0 || dmem_req !== 1'b0) begin n_err++; $display("FAIL alu_no_stall: stall %b req %b required 0 0", ldst_stall, dmem_req); end
        @(negedge clk);
        n_cmp++; if (ldst_valid !== 1'b0) begin n_err++; $display("FAIL alu_pulse: got %b required 0", ldst_valid); end
    endtask

    task automatic test_load_byte();
        drive_op(1, 0, 3'b000, 32'h103, 32'h0, 10'd7);
        #1;
        n_cmp++; if (ldst_stall !== 1'b1) begin n_err++; $display("FAIL lb_stall_accept: got %b required 1", ldst_stall); end
        @(negedge clk);
        exe_valid = 0;
        n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin n_err++; $display("FAIL lb_req: req %b we %b required 1 0", dmem_req, dmem_we); end
        n_cmp++; if (dmem_addr !== 32'h100) begin n_err++; $display("FAIL lb_addr: got %h required 00000100", dmem_addr); end
        n_cmp++; if (ldst_valid !== 1'b0 || ldst_stall !== 1'b1) begin n_err++; $display("FAIL lb_cycle1: valid %b stall %b required 0 1", ldst_valid, ldst_stall); end
        dmem_gnt = 1;
        @(negedge clk);
        n_cmp++; if (dbg_state !== 2'd2 || dmem_req !== 1'b0 || ldst_valid !== 1'b0) begin
            n_err++; $display("FAIL lb_resp: state %0d req %b valid %b required 2 0 0", dbg_state, dmem_req, ldst_valid);
        end
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h80FF_0000;
        @(negedge clk);
        dmem_rvalid = 0;
        n_cmp++; if (ldst_valid !== 1'b1 || ldst_memtoreg !== 1'b1) begin n_err++; $display("FAIL lb_valid_at_3: valid %b memtoreg %b required 1 1", ldst_valid, ldst_memtoreg); end
        n_cmp++; if (ldst_load_data !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data: got %h required ffffff80", ldst_load_data); end
        n_cmp++; if (ldst_addr_dst !== 10'd7 || dbg_state !== 2'd0) begin n_err++; $display("FAIL lb_dst_state: dst %0d state %0d required 7 0", ldst_addr_dst, dbg_state); end
        @(negedge clk);
        n_cmp++; if (ldst_valid !== 1'b0) begin n_err++; $display("FAIL lb_pulse: got %b required 0", ldst_valid); end
    endtask

    task automatic test_store_half_back_to_back();
        drive_op(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 10'd9);
        @(negedge clk);
        exe_valid = 0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h200 || dmem_be !== 4'b1100 ||
                         dmem_wdata !== 32'hABCD_ABCD || ldst_stall !== 1'b1 || ldst_valid !== 1'b0) begin
                n_err++; $display("FAIL sh_hold_%0d: req %b we %b addr %h be %b wdata %h stall %b valid %b required 1 1 00000200 1100 abcdabcd 1 0",
                                  i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ldst_stall, ldst_valid);
            end
            if (i == 3) dmem_gnt = 1;
            @(negedge clk);
        end
        dmem_gnt = 0;
        n_cmp++; if (ldst_valid !== 1'b1 || ldst_addr_dst !== 10'd0 || ldst_memtoreg !== 1'b0) begin
            n_err++; $display("FAIL sh_done: valid %b dst %0d memtoreg %b required 1 0 0", ldst_valid, ldst_addr_dst, ldst_memtoreg);
        end
        n_cmp++; if (dmem_req !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL sh_idle: req %b state %0d required 0 0", dmem_req, dbg_state); end
        drive_op(0, 0, 3'b000, 32'hCAFE, 32'h0, 10'd12);
        @(negedge clk);
        exe_valid = 0;
        n_cmp++; if (ldst_valid !== 1'b1 || ldst_addr_dst !== 10'd12 || ldst_alu_result !== 32'hCAFE) begin
            n_err++; $display("FAIL b2b_alu: valid %b dst %0d alu %h required 1 12 0000cafe", ldst_valid, ldst_addr_dst, ldst_alu_result);
        end
    endtask

    task automatic test_misaligned();
        drive_op(1, 0, 3'b010, 32'h101, 32'h0, 10'd2);
        #1;
        n_cmp++; if (ldst_stall !== 1'b0) begin n_err++; $display("FAIL mis_stall: got %b required 0", ldst_stall); end
        @(negedge clk);
        exe_valid = 0;
        n_cmp++; if (ldst_misaligned !== 1'b1 || ldst_valid !== 1'b0) begin n_err++; $display("FAIL mis_pulse: mis %b valid %b required 1 0", ldst_misaligned, ldst_valid); end
        n_cmp++; if (dmem_req !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL mis_noreq: req %b state %0d required 0 0", dmem_req, dbg_state); end
        @(negedge clk);
        n_cmp++; if (ldst_misaligned !== 1'b0) begin n_err++; $display("FAIL mis_one_cycle: got %b required 0", ldst_misaligned); end
    endtask

    task automatic test_load_hu();
        drive_op(1, 0, 3'b101, 32'h102, 32'h0, 10'd3);
        @(negedge clk);
        exe_valid = 0;
        dmem_rvalid = 1; dmem_rdata = 32'h1111_1111;
        @(negedge clk);
        n_cmp++; if (dbg_state !== 2'd1 || ldst_valid !== 1'b0 || dmem_req !== 1'b1) begin
            n_err++; $display("FAIL lhu_stray_rvalid: state %0d valid %b req %b required 1 0 1", dbg_state, ldst_valid, dmem_req);
        end
        dmem_rvalid = 0; dmem_gnt = 1;
        @(negedge clk);
        dmem_gnt = 1;
        @(negedge clk);
        dmem_gnt = 0;
        n_cmp++; if (dbg_state !== 2'd2 || ldst_valid !== 1'b0) begin n_err++; $display("FAIL lhu_gnt_in_resp: state %0d valid %b required 2 0", dbg_state, ldst_valid); end
        dmem_rvalid = 1; dmem_rdata = 32'h8001_0000;
        @(negedge clk);
        dmem_rvalid = 0;
        n_cmp++; if (ldst_valid !== 1'b1 || ldst_load_data !== 32'h0000_8001 || ldst_addr_dst !== 10'd3) begin
            n_err++; $display("FAIL lhu_data: valid %b data %h dst %0d required 1 00008001 3", ldst_valid, ldst_load_data, ldst_addr_dst);
        end
    endtask

    task automatic test_size_fallback();
        drive_op(0, 1, 3'b011, 32'h104, 32'h1122_3344, 10'd1);
        @(negedge clk);
        exe_valid = 0;
        n_cmp++; if (dmem_be !== 4'b1111 || dmem_wdata !== 32'h1122_3344 || dmem_addr !== 32'h104) begin
            n_err++; $display("FAIL f3_011_store: be %b wdata %h addr %h required 1111 11223344 00000104", dmem_be, dmem_wdata, dmem_addr);
        end
        dmem_gnt = 1;
        @(negedge clk);
        dmem_gnt = 0;
        drive_op(0, 1, 3'b000, 32'h10D, 32'h0012_345A, 10'd1);
        @(negedge clk);
        exe_valid = 0;
        n_cmp++; if (dmem_be !== 4'b0010 || dmem_wdata !== 32'h5A5A_5A5A || dmem_addr !== 32'h10C) begin
            n_err++; $display("FAIL sb_encode: be %b wdata %h addr %h required 0010 5a5a5a5a 0000010c", dmem_be, dmem_wdata, dmem_addr);
        end
        dmem_gnt = 1;
        @(negedge clk);
        dmem_gnt = 0;
        drive_op(1, 1, 3'b111, 32'h108, 32'hFFFF_FFFF, 10'd4);
        @(negedge clk);
        exe_valid = 0;
        n_cmp++; if (dmem_we !== 1'b0 || dmem_req !== 1'b1) begin n_err++; $display("FAIL both_is_load: we %b req %b required 0 1", dmem_we, dmem_req); end
        dmem_gnt = 1;
        @(negedge clk);
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_rvalid = 0;
        n_cmp++; if (ldst_valid !== 1'b1 || ldst_load_data !== 32'hDEAD_BEEF || ldst_memtoreg !== 1'b1) begin
            n_err++; $display("FAIL f3_111_load: valid %b data %h memtoreg %b required 1 deadbeef 1", ldst_valid, ldst_load_data, ldst_memtoreg);
        end
    endtask

    task automatic test_reset_mid_resp();
        drive_op(1, 0, 3'b010, 32'h300, 32'h0, 10'd6);
        @(negedge clk);
        exe_valid = 0; dmem_gnt = 1;
        @(negedge clk);
        dmem_gnt = 0;
        n_cmp++; if (dbg_state !== 2'd2) begin n_err++; $display("FAIL rst_pre_resp: state %0d required 2", dbg_state); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({ldst_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, ldst_valid,
                      ldst_memtoreg, ldst_addr_dst, ldst_alu_result, ldst_load_data,
                      ldst_misaligned, dbg_state} !== '0) begin
            n_err++; $display("FAIL rst_async: outputs or state nonzero during reset, required all 0");
        end
        @(negedge clk);
        rst_n = 1'b1; dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            n_cmp++; if (ldst_valid !== 1'b0 || ldst_load_data !== 32'h0 || dbg_state !== 2'd0) begin
                n_err++; $display("FAIL rst_stray_rvalid: valid %b data %h state %0d required 0 00000000 0", ldst_valid, ldst_load_data, dbg_state);
            end
        end
        dmem_rvalid = 0;
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_byte();
        test_store_half_back_to_back();
        test_misaligned();
        test_load_hu();
        test_size_fallback();
        test_reset_mid_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
